// File: rtl/and_operand_loader_pkg.sv
// Shared constants for the AND operand loader: FSM encoding and the operand width
// that must agree with the downstream multi_bit AND block.
package and_operand_loader_pkg;

    localparam int unsigned DefaultDataWidth = 4;

    localparam logic [1:0] StWaitA = 2'd0;
    localparam logic [1:0] StWaitB = 2'd1;
    localparam logic [1:0] StHold  = 2'd2;

endpackage

// File: rtl/and_operand_loader.sv
// Collects operand A then operand B over one valid/ready channel, holds the pair for the
// AND block until acknowledged, and counts acknowledged pairs (wrapping).
module and_operand_loader
    import and_operand_loader_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = DefaultDataWidth,
    parameter int unsigned CNT_WIDTH  = 8
) (
    input  logic                  clk_in,
    input  logic                  rst_in,
    input  logic [DATA_WIDTH-1:0] data_in,
    input  logic                  valid_in,
    output logic                  ready_out,
    output logic [DATA_WIDTH-1:0] a_out,
    output logic [DATA_WIDTH-1:0] b_out,
    output logic                  op_valid_out,
    input  logic                  op_ack_in,
    output logic [CNT_WIDTH-1:0]  pairs_out
);

    logic [1:0]            state_q, state_d;
    logic [DATA_WIDTH-1:0] a_q, a_d;
    logic [DATA_WIDTH-1:0] b_q, b_d;
    logic                  op_valid_q, op_valid_d;
    logic [CNT_WIDTH-1:0]  pairs_q, pairs_d;
    logic                  xfer;
    logic                  consume;

    // Ready depends on state only, so no combinational path from valid_in or op_ack_in.
    assign ready_out = (state_q != StHold);
    assign xfer      = valid_in && ready_out;
    assign consume   = (state_q == StHold) && op_ack_in;

    always_comb begin
        state_d = state_q;
        case (state_q)
            StWaitA: if (xfer) state_d = StWaitB;
            StWaitB: if (xfer) state_d = StHold;
            StHold:  if (op_ack_in) state_d = StWaitA;
            default: state_d = StWaitA;
        endcase
    end

    // Operands are only overwritten by a new transfer, never cleared on ack.
    always_comb begin
        a_d        = a_q;
        b_d        = b_q;
        op_valid_d = op_valid_q;
        if (xfer && (state_q == StWaitA)) begin
            a_d = data_in;
        end
        if (xfer && (state_q == StWaitB)) begin
            b_d        = data_in;
            op_valid_d = 1'b1;
        end
        if (consume) begin
            op_valid_d = 1'b0;
        end
    end

    always_comb begin
        pairs_d = pairs_q;
        if (consume) begin
            pairs_d = pairs_q + {{(CNT_WIDTH-1){1'b0}}, 1'b1};
        end
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            state_q    <= StWaitA;
            a_q        <= '0;
            b_q        <= '0;
            op_valid_q <= 1'b0;
            pairs_q    <= '0;
        end else begin
            state_q    <= state_d;
            a_q        <= a_d;
            b_q        <= b_d;
            op_valid_q <= op_valid_d;
            pairs_q    <= pairs_d;
        end
    end

    assign a_out        = a_q;
    assign b_out        = b_q;
    assign op_valid_out = op_valid_q;
    assign pairs_out    = pairs_q;

endmodule
